// File: rtl/neuron_mac_seq.sv
// Sequential dot-product neuron: sweeps one weight BRAM and the activation buffer,
// accumulates W*X on top of the shifted bias, then floors, saturates and optionally ReLUs.
module neuron_mac_seq #(
    parameter int N_IN      = 28,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              relu_en_i,
    input  logic [DATA_W-1:0] bias_i,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic              w_en_o,
    input  logic [DATA_W-1:0] w_do_i,
    input  logic [DATA_W-1:0] x_do_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] y_o,
    output logic              y_valid_o,
    output logic              done_o,
    output logic              ovf_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic                     en_q, en_d;
    logic                     busy_q, busy_d;
    logic [DATA_W-1:0]        y_q, y_d;
    logic                     yv_q, yv_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;
    logic                     relu_q, relu_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_acc;
    logic signed [ACC_W-1:0]    r;
    logic [DATA_W-1:0]          y_sat;
    logic                       sat;

    assign prod     = $signed(w_do_i) * $signed(x_do_i);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_acc = $signed({{(ACC_W-DATA_W){bias_i[DATA_W-1]}}, bias_i}) <<< FRAC_BITS;
    assign r        = acc_q >>> FRAC_BITS;

    // Clamp first so OVF reflects range overflow even when ReLU later zeroes the value.
    always_comb begin
        sat   = 1'b0;
        y_sat = r[DATA_W-1:0];
        if (r > Y_MAX) begin
            sat   = 1'b1;
            y_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (r < Y_MIN) begin
            sat   = 1'b1;
            y_sat = {1'b1, {(DATA_W-1){1'b0}}};
        end
        if (relu_q && y_sat[DATA_W-1]) y_sat = '0;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        en_d    = en_q;
        busy_d  = busy_q;
        y_d     = y_q;
        yv_d    = 1'b0;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        relu_d  = relu_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    relu_d  = relu_en_i;
                    acc_d   = bias_acc;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                acc_d  = acc_q + prod_ext;
                addr_d = addr_q + ADDR_W'(1);
                if (addr_d == LAST_ADDR) state_d = DRAIN;
            end
            DRAIN: begin
                acc_d   = acc_q + prod_ext;
                en_d    = 1'b0;
                state_d = FINISH;
            end
            FINISH: begin
                y_d     = y_sat;
                ovf_d   = sat;
                yv_d    = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            relu_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            relu_q  <= relu_d;
            acc_q   <= acc_d;
        end
    end

    assign w_addr_o  = addr_q;
    assign w_en_o    = en_q;
    assign busy_o    = busy_q;
    assign y_o       = y_q;
    assign y_valid_o = yv_q;
    assign done_o    = done_q;
    assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: negedge-read BRAM/buffer models plus a plain-arithmetic
// dot-product reference; directed cases followed by randomized runs.
module tb_neuron_mac_seq;
    localparam int N = 28;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, relu_en_i;
    logic [15:0] bias_i, w_do_i, x_do_i;
    logic [4:0]  w_addr_o;
    logic        w_en_o, busy_o, y_valid_o, done_o, ovf_o;
    logic [15:0] y_o;

    logic [15:0] wmem [N];
    logic [15:0] xmem [N];
    int total = 0;
    int bad   = 0;

    neuron_mac_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .relu_en_i(relu_en_i),
        .bias_i(bias_i), .w_addr_o(w_addr_o), .w_en_o(w_en_o), .w_do_i(w_do_i),
        .x_do_i(x_do_i), .busy_o(busy_o), .y_o(y_o), .y_valid_o(y_valid_o),
        .done_o(done_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Read data appears at the negedge after the address; garbage when not enabled.
    always @(negedge clk_i) begin
        if (w_en_o) begin
            w_do_i <= wmem[w_addr_o];
            x_do_i <= xmem[w_addr_o];
        end else begin
            w_do_i <= 16'($urandom);
            x_do_i <= 16'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] b, input bit relu,
                                  output logic [15:0] y, output bit o);
        longint s, r;
        s = longint'($signed(b)) * 256;
        for (int i = 0; i < N; i++)
            s += longint'($signed(wmem[i])) * longint'($signed(xmem[i]));
        r = s >>> 8;
        o = 1'b0;
        if (r > 32767) begin r = 32767; o = 1'b1; end
        else if (r < -32768) begin r = -32768; o = 1'b1; end
        if (relu && r < 0) r = 0;
        y = r[15:0];
    endfunction

    task automatic fill(input int mode, input logic [15:0] wc, input logic [15:0] xc);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: begin wmem[i] = wc; xmem[i] = xc; end
                1: begin wmem[i] = 16'($urandom); xmem[i] = 16'($urandom); end
                default: begin
                    wmem[i] = 16'($urandom_range(0, 1023) - 512);
                    xmem[i] = 16'($urandom_range(0, 1023) - 512);
                end
            endcase
        end
    endtask

    // Called at a negedge with the DUT idle; START is sampled at the next posedge (e0).
    task automatic run_check(input string tag, input logic [15:0] b, input bit relu, input bit repulse);
        logic [15:0] ey;
        bit eo, addr_ok;
        int lat, dones, na;
        model(b, relu, ey, eo);
        lat = -1; dones = 0; na = 0; addr_ok = 1'b1;
        start_i = 1'b1; bias_i = b; relu_en_i = relu;
        @(posedge clk_i); #1;
        start_i = 1'b0; bias_i = 16'($urandom); relu_en_i = 1'($urandom);
        @(negedge clk_i);
        check({tag, "/busy_e0"}, busy_o, 1);
        check({tag, "/wen_e0"}, w_en_o, 1);
        check({tag, "/ovf_e0"}, ovf_o, 0);
        if (w_en_o) begin
            if (w_addr_o != 0) addr_ok = 1'b0;
            na++;
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_i); #1;
            start_i = repulse && (c == 4 || c == 19);
            @(negedge clk_i);
            if (w_en_o) begin
                if (32'(w_addr_o) != na) addr_ok = 1'b0;
                na++;
            end
            if (y_valid_o && lat < 0) lat = c;
            if (done_o) dones++;
            if (c == 28) check({tag, "/busy_e28"}, busy_o, 1);
            if (c == 29) begin
                check({tag, "/busy_done"}, busy_o, 0);
                check({tag, "/done_with_yv"}, done_o, y_valid_o);
            end
        end
        check({tag, "/latency"}, lat, 29);
        check({tag, "/done_count"}, dones, 1);
        check({tag, "/addr_count"}, na, N);
        check({tag, "/addr_order"}, addr_ok, 1);
        check({tag, "/y"}, y_o, ey);
        check({tag, "/ovf"}, ovf_o, eo);
    endtask

    initial begin
        int yv_cyc[$];
        logic [15:0] ey;
        bit eo;
        int cnt;

        rst_i = 1'b1; start_i = 1'b0; relu_en_i = 1'b0; bias_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst/state_outs", {w_addr_o, w_en_o, busy_o, y_valid_o, done_o, ovf_o}, 0);
        check("rst/y", y_o, 0);
        rst_i = 1'b0;

        fill(0, 16'h0100, 16'h0100);
        run_check("ones", 16'h0000, 1'b0, 1'b0);
        check("ones/const", y_o, 16'h1C00);

        fill(0, 16'hFF00, 16'h0100);
        run_check("neg", 16'h0080, 1'b0, 1'b0);
        check("neg/const", y_o, 16'hE480);
        run_check("neg_relu", 16'h0080, 1'b1, 1'b0);
        check("neg_relu/const", y_o, 16'h0000);

        fill(0, 16'h7FFF, 16'h7FFF);
        run_check("sat", 16'h0000, 1'b0, 1'b0);
        check("sat/const", {ovf_o, y_o}, {1'b1, 16'h7FFF});

        fill(0, 16'h0100, 16'h0100);
        run_check("ovf_clear", 16'h0000, 1'b0, 1'b0);
        run_check("repulse", 16'h0000, 1'b0, 1'b1);

        // Abort mid-run: RST sampled at e10.
        start_i = 1'b1; bias_i = 16'h0000; relu_en_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("abort/ctrl", {busy_o, w_en_o, y_valid_o, done_o}, 0);
        check("abort/y", y_o, 0);
        cnt = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk_i);
            if (y_valid_o || busy_o) cnt++;
        end
        check("abort/quiet", cnt, 0);
        run_check("after_abort", 16'h0000, 1'b0, 1'b0);
        check("after_abort/const", y_o, 16'h1C00);

        // START held high: second run accepted at the edge right after DONE.
        start_i = 1'b1; bias_i = 16'h0000; relu_en_i = 1'b0;
        for (int c = 0; c <= 70; c++) begin
            @(posedge clk_i); #1;
            if (c == 30) start_i = 1'b0;
            @(negedge clk_i);
            if (y_valid_o) begin
                yv_cyc.push_back(c);
                check($sformatf("b2b/y%0d", yv_cyc.size()), y_o, 16'h1C00);
            end
            if (c == 30) check("b2b/busy_restart", busy_o, 1);
        end
        check("b2b/count", yv_cyc.size(), 2);
        if (yv_cyc.size() == 2) begin
            check("b2b/first", yv_cyc[0], 29);
            check("b2b/second", yv_cyc[1], 59);
        end

        for (int t = 0; t < 8; t++) begin
            fill((t % 2) + 1, 16'h0, 16'h0);
            run_check($sformatf("rand%0d", t), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        // Y must hold after the pulse.
        model(bias_i, 1'b0, ey, eo);
        repeat (5) @(negedge clk_i);
        check("hold/yv_low", y_valid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
